// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the instruction fetch stage
package fetch_pkg;

  // Fetch sequencer states
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam int RESET_VECTOR_DEF = 0;
  localparam int PC_INCR          = 4;

  // Shift-amount field position inside an instruction word
  localparam int SHAMT_LSB = 6;
  localparam int SHAMT_W   = 5;

endpackage

// File: rtl/pc_select.sv
// rtl/pc_select.sv - redirect detect and branch/jump target mux
module pc_select
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     jump,
  input  logic [ADDRESS_WIDTH-1:0] jump_target,
  input  logic                     branch,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  output logic                     redirect,
  output logic [ADDRESS_WIDTH-1:0] target
);

  // A jump overrides a branch resolved in the same cycle
  always_comb begin
    redirect = jump | branch;
    target   = jump ? jump_target : branch_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the F/D pipeline register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_StallF,
  input  logic                     i_PCSrcD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCBranchD,
  input  logic                     i_JumpD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCJumpD,
  output logic                     o_IMemReq,
  output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
  input  logic                     i_IMemReady,
  input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
  output logic [INSTR_WIDTH-1:0]   o_InstrF,
  output logic [ADDRESS_WIDTH-1:0] o_PCPlus4F,
  output logic [SHAMT_W-1:0]       o_ShamtF,
  output logic                     o_ValidF,
  output logic                     o_n_EN_FD,
  output logic                     o_CLR_FD
);

  logic [1:0]               state;
  logic [ADDRESS_WIDTH-1:0] r_FetchAddr;
  logic [ADDRESS_WIDTH-1:0] r_PendingAddr;
  logic [INSTR_WIDTH-1:0]   r_Buf;

  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [ADDRESS_WIDTH-1:0] addr_incr;

  pc_select #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_pc_select (
    .jump          (i_JumpD),
    .jump_target   (i_PCJumpD),
    .branch        (i_PCSrcD),
    .branch_target (i_PCBranchD),
    .redirect      (redirect),
    .target        (target)
  );

  assign addr_incr  = r_FetchAddr + ADDRESS_WIDTH'(PC_INCR);
  assign o_IMemAddr = r_FetchAddr;
  assign o_PCPlus4F = addr_incr;
  assign o_ShamtF   = o_InstrF[SHAMT_LSB +: SHAMT_W];
  assign o_n_EN_FD  = i_RST & i_StallF;
  assign o_CLR_FD   = i_RST & (redirect | (~o_ValidF & ~i_StallF));

  // Request, valid and instruction bypass per state; everything quiet while in reset
  always_comb begin
    o_IMemReq = 1'b0;
    o_ValidF  = 1'b0;
    o_InstrF  = '0;
    if (i_RST) begin
      case (state)
        ST_FETCH: begin
          o_IMemReq = 1'b1;
          o_ValidF  = i_IMemReady & ~redirect;
          o_InstrF  = i_IMemRdata;
        end
        ST_HOLD: begin
          o_ValidF = ~redirect;
          o_InstrF = r_Buf;
        end
        ST_DROP: begin
          o_IMemReq = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fetch sequencer: advance, park a stalled word, or drain a request made stale by a redirect
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state         <= ST_FETCH;
      r_FetchAddr   <= RESET_VECTOR;
      r_PendingAddr <= '0;
      r_Buf         <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (i_IMemReady) begin
            if (redirect) begin
              r_FetchAddr <= target;
            end else if (!i_StallF) begin
              r_FetchAddr <= addr_incr;
            end else begin
              r_Buf <= i_IMemRdata;
              state <= ST_HOLD;
            end
          end else if (redirect) begin
            // The outstanding address must stay on the bus until its ready returns
            r_PendingAddr <= target;
            state         <= ST_DROP;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            r_FetchAddr <= target;
            state       <= ST_FETCH;
          end else if (!i_StallF) begin
            r_FetchAddr <= addr_incr;
            state       <= ST_FETCH;
          end
        end
        ST_DROP: begin
          if (i_IMemReady) begin
            r_FetchAddr <= redirect ? target : r_PendingAddr;
            state       <= ST_FETCH;
          end else if (redirect) begin
            r_PendingAddr <= target;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pcsrc;
  logic [31:0] btgt;
  logic        jump;
  logic [31:0] jtgt;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic [4:0]  shamt;
  logic        valid;
  logic        nen;
  logic        clr;

  fetch_unit dut (
    .i_CLK       (clk),
    .i_RST       (rst_n),
    .i_StallF    (stall),
    .i_PCSrcD    (pcsrc),
    .i_PCBranchD (btgt),
    .i_JumpD     (jump),
    .i_PCJumpD   (jtgt),
    .o_IMemReq   (req),
    .o_IMemAddr  (addr),
    .i_IMemReady (ready),
    .i_IMemRdata (rdata),
    .o_InstrF    (instr),
    .o_PCPlus4F  (pc4),
    .o_ShamtF    (shamt),
    .o_ValidF    (valid),
    .o_n_EN_FD   (nen),
    .o_CLR_FD    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the address being fetched, whether the in-flight word is stale, and a parked word
  logic [31:0] m_addr;
  logic        m_drop;
  logic [31:0] m_next;
  logic        m_hold;
  logic [31:0] m_held;

  // Memory responder
  bit          mem_busy;
  int          mem_lat;
  int          lat_fix;
  bit          use_dir_data;
  logic [31:0] dir_data;

  // Last sampled outputs for directed checks
  logic        obs_req;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc4;
  logic [31:0] obs_instr;
  logic [4:0]  obs_shamt;
  logic        obs_valid;
  logic        obs_nen;
  logic        obs_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr   = 32'h0;
    m_drop   = 1'b0;
    m_next   = 32'h0;
    m_hold   = 1'b0;
    m_held   = 32'h0;
    mem_busy = 1'b0;
    mem_lat  = 0;
  endtask

  // One clock: drive inputs after the falling edge, check outputs, then advance the model at the rising edge
  task automatic step(input logic s, input logic ps, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic        redir;
    logic        er;
    logic        ev;
    logic        rdy;
    logic [31:0] tgt;
    logic [31:0] ei;
    logic [31:0] dat;
    @(negedge clk);
    stall = s;
    pcsrc = ps;
    btgt  = bt;
    jump  = j;
    jtgt  = jt;
    er    = !m_hold;
    if (er && !mem_busy)
      mem_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    rdy   = er && (mem_lat == 0);
    dat   = use_dir_data ? dir_data : $urandom();
    ready = rdy;
    rdata = dat;
    #1;
    redir = j | ps;
    tgt   = j ? jt : bt;
    ev    = m_hold ? !redir : (!m_drop && rdy && !redir);
    obs_req   = req;
    obs_addr  = addr;
    obs_pc4   = pc4;
    obs_instr = instr;
    obs_shamt = shamt;
    obs_valid = valid;
    obs_nen   = nen;
    obs_clr   = clr;
    check("req", req, er);
    check("addr", addr, m_addr);
    check("pc4", pc4, m_addr + 32'd4);
    check("valid", valid, ev);
    check("n_en", nen, s);
    check("clr", clr, redir | (!ev && !s));
    if (ev || m_drop) begin
      ei = m_hold ? m_held : (m_drop ? 32'h0 : dat);
      check("instr", instr, ei);
      check("shamt", shamt, (ei >> 6) & 32'h1f);
    end
    @(posedge clk);
    if (m_hold) begin
      if (redir) begin
        m_addr = tgt;
        m_hold = 1'b0;
      end else if (!s) begin
        m_addr = m_addr + 32'd4;
        m_hold = 1'b0;
      end
    end else if (m_drop) begin
      if (redir) m_next = tgt;
      if (rdy) begin
        m_addr = m_next;
        m_drop = 1'b0;
      end
    end else if (rdy) begin
      if (redir) m_addr = tgt;
      else if (!s) m_addr = m_addr + 32'd4;
      else begin
        m_hold = 1'b1;
        m_held = dat;
      end
    end else if (redir) begin
      m_drop = 1'b1;
      m_next = tgt;
    end
    if (rdy) mem_busy = 1'b0;
    else if (er) begin
      mem_busy = 1'b1;
      mem_lat--;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  logic [31:0] held_word;

  initial begin
    rst_n        = 1'b0;
    stall        = 1'b1;
    pcsrc        = 1'b0;
    jump         = 1'b1;
    btgt         = 32'h0;
    jtgt         = 32'h40;
    ready        = 1'b0;
    rdata        = 32'h0;
    lat_fix      = 0;
    use_dir_data = 1'b0;
    dir_data     = 32'h0;
    model_reset();

    // Outputs held quiet in reset even with stall and jump asserted
    #12;
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, 32'h0);
    check("rst_pc4", pc4, 32'h4);
    check("rst_valid", valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_clr", clr, 1'b0);
    check("rst_nen", nen, 1'b0);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    stall = 1'b0;
    jump  = 1'b0;

    // Zero-wait memory: one instruction per cycle
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t1_addr", obs_addr, 32'(i * 4));
      check("t1_pc4", obs_pc4, 32'(i * 4 + 4));
      check("t1_valid", obs_valid, 1'b1);
    end
    idle();

    // Three wait states at 0x10
    lat_fix      = 3;
    use_dir_data = 1'b1;
    dir_data     = 32'h012A4020;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("t2_addr", obs_addr, 32'h10);
      check("t2_req", obs_req, 1'b1);
      if (i < 3) check("t2_clr", obs_clr, 1'b1);
    end
    check("t2_valid", obs_valid, 1'b1);
    check("t2_instr", obs_instr, 32'h012A4020);
    check("t2_shamt", obs_shamt, 5'd0);
    lat_fix = 0;
    for (int i = 0; i < 3; i++) idle();

    // Ready at 0x20 with a two-cycle stall
    dir_data  = 32'h0000_07C0;
    held_word = dir_data;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t3_addr", obs_addr, 32'h20);
    check("t3_nen", obs_nen, 1'b1);
    check("t3_clr0", obs_clr, 1'b0);
    use_dir_data = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t3_req", obs_req, 1'b0);
    check("t3_instr", obs_instr, held_word);
    check("t3_shamt", obs_shamt, 5'h1f);
    check("t3_clr1", obs_clr, 1'b0);
    idle();
    check("t3_rel_valid", obs_valid, 1'b1);
    idle();
    check("t3_next", obs_addr, 32'h24);
    idle();
    idle();

    // Branch while fetch at 0x30 is waiting
    lat_fix = 3;
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    check("t4_addr0", obs_addr, 32'h30);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t4_addr", obs_addr, 32'h30);
      check("t4_valid", obs_valid, 1'b0);
    end
    check("t4_instr", obs_instr, 32'h0);
    lat_fix = 0;

    // Jump and branch together on a zero-wait ready: jump wins
    step(1'b0, 1'b1, 32'h300, 1'b1, 32'h200);
    check("t5_addr", obs_addr, 32'h100);
    check("t5_clr", obs_clr, 1'b1);
    check("t5_valid", obs_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    check("t5_next", obs_addr, 32'h200);

    // Address wrap
    idle();
    check("t6_addr", obs_addr, 32'hFFFF_FFFC);
    check("t6_pc4", obs_pc4, 32'h0);
    idle();
    check("t6_wrap", obs_addr, 32'h0);

    // Reset while draining a stale request
    lat_fix = 3;
    step(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    check("t7_req", req, 1'b0);
    check("t7_addr", addr, 32'h0);
    check("t7_valid", valid, 1'b0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    lat_fix = 0;
    idle();
    check("t7_addr_after", obs_addr, 32'h0);
    check("t7_req_after", obs_req, 1'b1);

    // Randomized traffic
    lat_fix = -1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom() & 32'hFFFF_FFFC,
           ($urandom % 10) == 0, $urandom() & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
